load_store_unit: RTL and testbench

- Sits between the CPU execute stage and the word-wide data memory.
- Converts byte, halfword and word load/store requests into word-indexed memory accesses on the memory's exclusive read/write enables.
- Performs read-modify-write for sub-word stores and sign/zero extension for loads.
- Reports misaligned and out-of-range accesses without touching memory.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared size encodings and FSM state type for the load/store
//                unit and its lane-alignment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    // Access size encodings carried on req_size; 2'b11 is illegal
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Little-endian lane steering. Extracts and sign/zero-extends
//                the addressed byte/half of a memory word for loads, and
//                merges right-aligned store data into that word for
//                sub-word stores.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    // Lane select, extension and merge; the untouched lanes keep the memory word
    always_comb begin
        byte_w       = word_i[{addr_i, 3'b000} +: 8];
        half_w       = word_i[{addr_i[1], 4'b0000} +: 16];
        load_data_o  = word_i;
        merge_data_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {{24{signed_i & byte_w[7]}}, byte_w};
                merge_data_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_data_o = {{16{signed_i & half_w[15]}}, half_w};
                merge_data_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                // Word (and the never-issued illegal size) passes straight through
                load_data_o  = word_i;
                merge_data_o = wdata_i;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Converts byte/half/word load/store requests into word-indexed
//                accesses on a memory with exclusive read/write enables.
//                Sub-word stores are done as read-modify-write; misaligned,
//                out-of-range and illegal-size requests respond with an error
//                without enabling memory.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_readenable,
    output logic        mem_writeenable,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_outdata
);

    lsu_state_e  state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] writedata_q;

    logic        accept_w;
    logic        err_w;
    logic [31:0] load_data_w;
    logic [31:0] merge_data_w;

    assign req_ready       = (state_q == IDLE);
    assign accept_w        = req_valid && req_ready;
    assign mem_readenable  = (state_q == RD);
    assign mem_writeenable = (state_q == WR);
    assign mem_addr        = {2'b00, addr_q[31:2]};
    assign mem_writedata   = writedata_q;
    assign resp_valid      = (state_q == RESP);
    assign resp_err        = (state_q == RESP) && err_q;
    assign resp_rdata      = rdata_q;

    // Request legality, evaluated on the live request so the FSM can skip memory
    always_comb begin
        err_w = 1'b0;
        if (req_size == 2'b11)                                err_w = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])               err_w = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)    err_w = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))        err_w = 1'b1;
    end

    lsu_lane_align u_lane_align (
        .word_i       (mem_outdata),
        .addr_i       (addr_q[1:0]),
        .size_i       (size_q),
        .signed_i     (signed_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data_w),
        .merge_data_o (merge_data_w)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode: errors go straight to RESP, word stores skip the read
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    if (err_w)                               state_d = RESP;
                    else if (req_write && req_size == SZ_WORD) state_d = WR;
                    else                                     state_d = RD;
                end
            end
            RD:      state_d = write_q ? WR : RESP;
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, load result and merged store word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            writedata_q <= '0;
        end else begin
            if (accept_w) begin
                write_q     <= req_write;
                size_q      <= req_size;
                signed_q    <= req_signed;
                addr_q      <= req_addr;
                wdata_q     <= req_wdata;
                err_q       <= err_w;
                rdata_q     <= '0;
                writedata_q <= req_wdata;
            end else if (state_q == RD) begin
                if (write_q) writedata_q <= merge_data_w;
                else         rdata_q     <= load_data_w;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit with a
//                behavioural word memory (negedge read, posedge write).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    localparam int MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_readenable;
    logic        mem_writeenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_outdata;

    logic [31:0] mem [MEM_WORDS];

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_err        (resp_err),
        .resp_rdata      (resp_rdata),
        .mem_addr        (mem_addr),
        .mem_readenable  (mem_readenable),
        .mem_writeenable (mem_writeenable),
        .mem_writedata   (mem_writedata),
        .mem_outdata     (mem_outdata)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: read data appears mid-cycle, writes commit at posedge
    always @(negedge clk) if (mem_readenable) mem_outdata <= mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_writeenable) mem[mem_addr[7:0]] <= mem_writedata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge and follow it to its response
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                          input int exp_re, input int exp_we, input logic [31:0] exp_wd);
        int lat = 0;
        int re_cnt = 0;
        int we_cnt = 0;
        bit seen = 0;
        for (int i = 0; i < 8 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_readenable) begin
                re_cnt++;
                chk({tag, "_rd_addr"}, mem_addr, addr >> 2);
            end
            if (mem_writeenable) begin
                we_cnt++;
                chk({tag, "_wr_addr"}, mem_addr, addr >> 2);
                chk({tag, "_wr_data"}, mem_writedata, exp_wd);
            end
            if (resp_valid) begin
                seen = 1;
                lat  = c;
            end
        end
        chk({tag, "_resp_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        if (!wr || exp_err) chk({tag, "_rdata"}, resp_rdata, exp_rd);
        chk({tag, "_re_cycles"}, 32'(re_cnt), 32'(exp_re));
        chk({tag, "_we_cycles"}, 32'(we_cnt), 32'(exp_we));
    endtask

    initial begin
        logic [31:0] exp_q [3];
        int          n_resp;
        int          k;
        bit          quiet;

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
        mem_outdata = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",   {31'd0, req_ready},       32'd1);
        chk("rst_rvalid",  {31'd0, resp_valid},      32'd0);
        chk("rst_rerr",    {31'd0, resp_err},        32'd0);
        chk("rst_rdata",   resp_rdata,               32'd0);
        chk("rst_re",      {31'd0, mem_readenable},  32'd0);
        chk("rst_we",      {31'd0, mem_writeenable}, 32'd0);
        chk("rst_maddr",   mem_addr,                 32'd0);
        chk("rst_mwdata",  mem_writedata,            32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //       tag    wr    size   sg    addr      wdata         err   rdata         lat re we wdata
        do_req("sw",   1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        2, 0, 1, 32'hDEADBEEF);
        do_req("lb",   1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        1'b0, 32'hFFFFFFDE, 2, 1, 0, 32'h0);
        do_req("lbu",  1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        1'b0, 32'h000000DE, 2, 1, 0, 32'h0);
        do_req("sh",   1'b1, 2'b01, 1'b0, 32'h12,  32'h00001234, 1'b0, 32'h0,        3, 1, 1, 32'h1234BEEF);
        do_req("lw",   1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        1'b0, 32'h1234BEEF, 2, 1, 0, 32'h0);
        do_req("lh_hi",1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        1'b0, 32'h00001234, 2, 1, 0, 32'h0);
        do_req("lh_lo",1'b0, 2'b01, 1'b1, 32'h10,  32'h0,        1'b0, 32'hFFFFBEEF, 2, 1, 0, 32'h0);
        do_req("lhu",  1'b0, 2'b01, 1'b0, 32'h10,  32'h0,        1'b0, 32'h0000BEEF, 2, 1, 0, 32'h0);
        do_req("sb",   1'b1, 2'b00, 1'b0, 32'h11,  32'hFFFFFFAA, 1'b0, 32'h0,        3, 1, 1, 32'h1234AAEF);
        do_req("lb1",  1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        1'b0, 32'hFFFFFFAA, 2, 1, 0, 32'h0);
        do_req("e_lw", 1'b0, 2'b10, 1'b0, 32'h11,  32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0);
        do_req("e_sh", 1'b1, 2'b01, 1'b0, 32'h01,  32'h5555,     1'b1, 32'h0,        1, 0, 0, 32'h0);
        do_req("e_sz", 1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0);
        do_req("e_rng",1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0);
        do_req("lw_top",1'b0,2'b10, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'h0,        2, 1, 0, 32'h0);

        // Back-to-back loads with req_valid held high throughout
        exp_q[0] = 32'h1234AAEF; exp_q[1] = 32'h000000AA; exp_q[2] = 32'h00001234;
        n_resp = 0;
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_signed = 1'b0;
        req_size = 2'b10; req_addr = 32'h10;
        for (int c = 0; c < 30 && n_resp < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("b2b_ready", {31'd0, req_ready},
                {31'd0, !(mem_readenable || mem_writeenable || resp_valid)});
            if (resp_valid) begin
                chk($sformatf("b2b_rdata%0d", n_resp), resp_rdata, exp_q[n_resp]);
                n_resp++;
                if (n_resp == 1) begin req_size = 2'b00; req_addr = 32'h11; end
                if (n_resp == 2) begin req_size = 2'b01; req_addr = 32'h12; end
            end
        end
        req_valid = 1'b0;
        chk("b2b_count", 32'(n_resp), 32'd3);
        @(negedge clk);

        // Reset landing on the RD cycle of a byte store must abandon it cleanly
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstrd_in_rd", {31'd0, mem_readenable}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstrd_ready", {31'd0, req_ready}, 32'd1);
        quiet = 1;
        k = 0;
        while (k < 4) begin
            if (mem_writeenable || resp_valid || mem_readenable) quiet = 0;
            @(negedge clk);
            k++;
        end
        chk("rstrd_quiet", 32'(quiet), 32'd1);
        chk("rstrd_mem", mem[4], 32'h1234AAEF);
        do_req("rstrd_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1234AAEF, 2, 1, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
